// File: rtl/rmap_crc_rom_arbiter.sv
// Shares one registered 512x8 RMAP CRC ROM among NUM_CH byte streams, one CRC-8 accumulator per channel.
// Latency: ch_ready/rom_addr combinational in the grant cycle; accumulator updated two edges after grant.
// Backpressure: round-robin grant to one eligible channel per cycle; a channel with a lookup in flight is held off.
module rmap_crc_rom_arbiter #(
   parameter int         NUM_CH   = 2,
   parameter logic [7:0] CRC_INIT = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     ch_start,
   input  logic [NUM_CH-1:0]     ch_tbl_sel,
   input  logic [NUM_CH-1:0]     ch_valid,
   input  logic [8*NUM_CH-1:0]   ch_data,
   output logic [NUM_CH-1:0]     ch_ready,
   output logic [8*NUM_CH-1:0]   ch_crc,
   output logic [NUM_CH-1:0]     ch_busy,
   output logic [NUM_CH-1:0]     ch_crc_zero,
   output logic [8:0]            rom_addr,
   input  logic [7:0]            rom_data
);

   localparam int              PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [PW:0]     NCH_W = (PW+1)'(NUM_CH);
   localparam logic [PW-1:0]   LAST  = PW'(NUM_CH - 1);

   logic [7:0]        crc_q [NUM_CH];
   logic [7:0]        data_a [NUM_CH];
   logic [NUM_CH-1:0] busy_q;
   logic [NUM_CH-1:0] sel_q;
   logic [PW-1:0]     ptr_q;
   logic [PW-1:0]     tag_q;
   logic [8:0]        addr_q;

   logic [NUM_CH-1:0] elig;
   logic              gnt_vld;
   logic [PW-1:0]     gnt_idx;
   logic [PW:0]       sum;
   logic [PW-1:0]     idx;

   // Unpack the per-channel byte lanes for indexed access by the granted channel.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         data_a[i] = ch_data[8*i +: 8];
      end
   end

   // A start on a channel suppresses its grant; a pending lookup also blocks it.
   always_comb begin
      elig = ch_valid & ~busy_q & ~ch_start;
   end

   // Round-robin search: first eligible channel at or above the pointer, wrapping.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= NCH_W) begin
            sum = sum - NCH_W;
         end
         idx = sum[PW-1:0];
         if (!gnt_vld && elig[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   // ROM address follows the grant; it holds between grants and reads zero while in reset.
   always_comb begin
      rom_addr = addr_q;
      if (rst) begin
         rom_addr = '0;
      end else if (gnt_vld) begin
         rom_addr = {sel_q[gnt_idx], crc_q[gnt_idx] ^ data_a[gnt_idx]};
      end
   end

   // One-hot accept strobe for the granted channel.
   always_comb begin
      ch_ready = '0;
      if (!rst && gnt_vld) begin
         ch_ready[gnt_idx] = 1'b1;
      end
   end

   // Expose accumulators and the received-CRC-good flag.
   always_comb begin
      ch_crc      = '0;
      ch_crc_zero = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_crc[8*i +: 8] = crc_q[i];
         ch_crc_zero[i]   = (crc_q[i] == 8'h00) & ~busy_q[i];
      end
      ch_busy = busy_q;
   end

   // Arbitration pointer, in-flight tag, held ROM address and per-channel accumulators.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            crc_q[i] <= CRC_INIT;
         end
         busy_q <= '0;
         sel_q  <= '0;
         ptr_q  <= '0;
         tag_q  <= '0;
         addr_q <= '0;
      end else begin
         addr_q <= rom_addr;
         if (gnt_vld) begin
            tag_q <= gnt_idx;
            ptr_q <= (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_start[i]) begin
               // Restart wins over a returning lookup, which is simply dropped.
               crc_q[i] <= CRC_INIT;
               sel_q[i] <= ch_tbl_sel[i];
               busy_q[i] <= 1'b0;
            end else if (gnt_vld && gnt_idx == PW'(i)) begin
               busy_q[i] <= 1'b1;
            end else if (busy_q[i] && tag_q == PW'(i)) begin
               crc_q[i]  <= rom_data;
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rmap_crc_rom_arbiter.sv
// Bench for rmap_crc_rom_arbiter with a registered CRC ROM model and a scoreboard monitor.
// Driver pushes expected ROM address / resulting CRC per offered byte; monitor pops on each grant.
// Arbitration, busy, address hold and delayed accumulator values are checked every cycle.
module tb_rmap_crc_rom_arbiter;

   localparam int         NCH  = 3;
   localparam logic [7:0] INIT = 8'h00;

   typedef struct packed {
      logic [8:0] addr;
      logic [7:0] crc;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       ch_start, ch_tbl_sel, ch_valid, ch_ready, ch_busy, ch_crc_zero;
   logic [8*NCH-1:0]     ch_data, ch_crc;
   logic [8:0]           rom_addr;
   logic [7:0]           rom_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   rmap_crc_rom_arbiter #(.NUM_CH(NCH), .CRC_INIT(INIT)) dut (
      .clk(clk), .rst(rst), .ch_start(ch_start), .ch_tbl_sel(ch_tbl_sel),
      .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready), .ch_crc(ch_crc),
      .ch_busy(ch_busy), .ch_crc_zero(ch_crc_zero), .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always #5 clk = ~clk;

   // Table 0: CRC-8 poly 0x07 MSB-first; table 1: reflected form (0xE0) as used by RMAP.
   function automatic logic [7:0] tbl(input logic sel, input logic [7:0] v);
      logic [7:0] c;
      c = v;
      for (int b = 0; b < 8; b++) begin
         if (sel) c = c[0] ? ((c >> 1) ^ 8'hE0) : (c >> 1);
         else     c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   // Registered lookup ROM.
   always @(posedge clk) rom_data <= tbl(rom_addr[8], rom_addr[7:0]);

   function automatic logic [7:0] crc_of(input int i);
      return ch_crc[8*i +: 8];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver-side reference state ----------------
   logic [7:0]     mcrc [NCH];
   logic [7:0]     pcrc [NCH];
   logic           msel [NCH];
   exp_t           exp_q [NCH][$];
   logic [NCH-1:0] acc;
   logic [8:0]     g_addr;

   task automatic clear_model();
      for (int i = 0; i < NCH; i++) begin
         mcrc[i] = INIT;
         msel[i] = 1'b0;
         exp_q[i].delete();
      end
      ch_start = '0; ch_tbl_sel = '0; ch_valid = '0; ch_data = '0;
   endtask

   task automatic step();
      @(negedge clk);
      acc = ch_ready;
      if (|ch_ready) g_addr = rom_addr;
      @(posedge clk);
      #1;
      cyc++;
      ch_start = '0;
      ch_valid = ch_valid & ~acc;
   endtask

   task automatic offer(input int i, input logic [7:0] b);
      exp_t e;
      pcrc[i] = mcrc[i];
      e.addr  = {msel[i], mcrc[i] ^ b};
      e.crc   = tbl(msel[i], mcrc[i] ^ b);
      mcrc[i] = e.crc;
      exp_q[i].push_back(e);
      ch_data[8*i +: 8] = b;
      ch_valid[i] = 1'b1;
   endtask

   task automatic withdraw(input int i);
      exp_t e;
      ch_valid[i] = 1'b0;
      e = exp_q[i].pop_back();
      mcrc[i] = pcrc[i];
   endtask

   task automatic do_start(input int i, input logic s);
      ch_start[i]   = 1'b1;
      ch_tbl_sel[i] = s;
      mcrc[i]       = INIT;
      msel[i]       = s;
   endtask

   task automatic wait_acc(input int i);
      int n;
      n = 0;
      step();
      while (!acc[i] && n < 20) begin
         step();
         n++;
      end
      chk($sformatf("accept_ch%0d", i), 32'(acc[i]), 1);
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [NCH-1:0] prev_gnt, m_elig, m_eg;
   int             mptr, m_g;
   logic [8:0]     last_addr;
   exp_t           m_e, d1e, d2e;
   int             d1c, d2c;
   bit             d1v, d2v;

   always @(negedge clk) begin
      if (rst) begin
         d1v = 0; d2v = 0; prev_gnt = '0; mptr = 0; last_addr = '0;
      end else begin
         m_elig = ch_valid & ~prev_gnt & ~ch_start;
         m_g = -1;
         for (int k = 0; k < NCH; k++) begin
            if (m_g < 0 && m_elig[(mptr + k) % NCH]) m_g = (mptr + k) % NCH;
         end
         m_eg = '0;
         if (m_g >= 0) m_eg[m_g] = 1'b1;
         chk("busy", 32'(ch_busy), 32'(prev_gnt));
         chk("ready", 32'(ch_ready), 32'(m_eg));
         if (d2v) begin
            chk($sformatf("crc_ch%0d", d2c), 32'(crc_of(d2c)), 32'(d2e.crc));
            chk($sformatf("crc_zero_ch%0d", d2c), 32'(ch_crc_zero[d2c]), 32'(d2e.crc == 8'h00));
         end
         d2v = d1v; d2c = d1c; d2e = d1e;
         d1v = 0;
         if (m_g >= 0) begin
            if (exp_q[m_g].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: grant ch%0d with no byte offered", m_g);
            end else begin
               m_e = exp_q[m_g].pop_front();
               chk("rom_addr", 32'(rom_addr), 32'(m_e.addr));
               last_addr = m_e.addr;
               d1v = 1; d1c = m_g; d1e = m_e;
            end
            mptr = (m_g + 1) % NCH;
         end else begin
            chk("rom_addr_hold", 32'(rom_addr), 32'(last_addr));
         end
         // A restart in this cycle discards the lookup returning at this edge.
         if (d2v && ch_start[d2c]) d2e.crc = INIT;
         prev_gnt = m_eg;
      end
   end

   // ---------------- stimulus ----------------
   int order[$];

   initial begin
      rst = 1'b1;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_crc", 32'(ch_crc), 32'({NCH{INIT}}));
      chk("rst_busy", 32'(ch_busy), 0);
      chk("rst_ready", 32'(ch_ready), 0);
      chk("rst_addr", 32'(rom_addr), 0);
      chk("rst_zero", 32'(ch_crc_zero), 32'({NCH{INIT == 8'h00}}));
      rst = 1'b0;

      // Two channels interleaving at full rate.
      do_start(0, 1'b0); do_start(1, 1'b0); step();
      offer(0, 8'h01); offer(1, 8'hFF);
      for (int s = 0; s < 6; s++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               order.push_back(i);
               if (order.size() <= 2) offer(i, (i == 0) ? 8'h01 : 8'hFF);
            end
         end
         if (s == 2) begin
            chk("il_crc0", 32'(crc_of(0)), 32'h07);
            chk("il_crc1", 32'(crc_of(1)), 32'hf3);
         end
      end
      chk("il_grants", order.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < order.size()) chk($sformatf("il_order%0d", k), order[k], k % 2);
      end

      // Single byte on ch0.
      do_start(0, 1'b0); step();
      offer(0, 8'h01); wait_acc(0);
      chk("t1_addr", 32'(g_addr), 32'h001);
      chk("t1_busy", 32'(ch_busy[0]), 1);
      step();
      chk("t1_crc", 32'(crc_of(0)), 32'h07);
      chk("t1_busy_clr", 32'(ch_busy[0]), 0);

      // Back-to-back bytes on one channel: one per two cycles.
      do_start(0, 1'b0); step();
      offer(0, 8'h01); wait_acc(0);
      begin
         int t1;
         t1 = cyc;
         offer(0, 8'h02); wait_acc(0);
         chk("t2_gap", cyc - t1, 2);
      end
      chk("t2_addr", 32'(g_addr), 32'h005);
      step();
      chk("t2_crc", 32'(crc_of(0)), 32'h1b);

      // Reflected table on ch1.
      do_start(1, 1'b1); step();
      offer(1, 8'h01); wait_acc(1);
      chk("t4_addr", 32'(g_addr), 32'h101);
      step();
      chk("t4_crc", 32'(crc_of(1)), 32'h91);

      // Restart while a lookup is in flight.
      do_start(0, 1'b0); step();
      offer(0, 8'h01); wait_acc(0);
      do_start(0, 1'b0); step();
      chk("t5_crc", 32'(crc_of(0)), 32'(INIT));
      chk("t5_busy", 32'(ch_busy[0]), 0);
      step();
      chk("t5_crc_hold", 32'(crc_of(0)), 32'(INIT));

      // Randomized traffic: offers, withdrawals, restarts on idle channels.
      for (int it = 0; it < 1500; it++) begin
         for (int i = 0; i < NCH; i++) begin
            if (ch_valid[i]) begin
               if ($urandom_range(9) == 0) withdraw(i);
            end else begin
               if ($urandom_range(15) == 0) do_start(i, 1'($urandom_range(1)));
               if ($urandom_range(2) != 0) offer(i, 8'($urandom));
            end
         end
         step();
      end
      for (int i = 0; i < NCH; i++) if (ch_valid[i]) withdraw(i);
      repeat (4) step();

      // Residue reaches zero, then asynchronous reset mid-stream.
      do_start(0, 1'b0); step();
      offer(0, 8'h01); wait_acc(0);
      offer(0, 8'h07); wait_acc(0);
      step();
      chk("t6_crc", 32'(crc_of(0)), 32'h00);
      chk("t6_zero", 32'(ch_crc_zero[0]), 1);
      do_start(1, 1'b0); step();
      offer(1, 8'hFF); wait_acc(1);
      step();
      offer(1, 8'h01); wait_acc(1);
      offer(0, 8'h55);
      #1 rst = 1'b1;
      #1;
      chk("ar_crc", 32'(ch_crc), 32'({NCH{INIT}}));
      chk("ar_busy", 32'(ch_busy), 0);
      chk("ar_ready", 32'(ch_ready), 0);
      chk("ar_addr", 32'(rom_addr), 0);
      chk("ar_zero", 32'(ch_crc_zero), 32'({NCH{INIT == 8'h00}}));
      repeat (2) @(posedge clk);
      clear_model();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
